// File: rtl/vdp_pkg.sv
// Shared widths, control-byte codes and state encodings for the VDP CPU port.
package vdp_pkg;
  localparam int VRAM_AW    = 14;
  localparam int REG_AW     = 3;
  localparam int FIFO_DEPTH = 4;

  localparam logic [1:0] CMD_WR = 2'b01;
  localparam logic [1:0] CMD_RD = 2'b00;

  // CMD_REG is 2'b1x: any second byte with bit 7 set is a register write
  function automatic logic cmd_is_reg(input logic [1:0] code);
    return code[1];
  endfunction

  typedef enum logic {LATCH_FIRST, LATCH_SECOND} latch_e;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_WREQ, SEQ_RREQ} seq_e;
endpackage

// File: rtl/vdp_cpu_port_if.sv
// CPU bus, register/status side-band and VRAM slot signals of the VDP CPU port.
interface vdp_cpu_port_if #(
  parameter int VRAM_AW = vdp_pkg::VRAM_AW,
  parameter int REG_AW  = vdp_pkg::REG_AW
);
  logic               chipSelect;
  logic               mode;
  logic               writeEnabled;
  logic               readStrobe;
  logic [7:0]         dataIn;
  logic [7:0]         dataOut;
  logic               busy;
  logic               regWrite;
  logic [REG_AW-1:0]  regAddr;
  logic [7:0]         regData;
  logic [7:0]         status;
  logic               statusRead;
  logic               vramReq;
  logic               vramWe;
  logic [VRAM_AW-1:0] vramAddr;
  logic [7:0]         vramWData;
  logic               vramAck;
  logic [7:0]         vramRData;

  modport slave (
    input  chipSelect, mode, writeEnabled, readStrobe, dataIn, status, vramAck, vramRData,
    output dataOut, busy, regWrite, regAddr, regData, statusRead,
           vramReq, vramWe, vramAddr, vramWData
  );

  modport master (
    output chipSelect, mode, writeEnabled, readStrobe, dataIn, status, vramAck, vramRData,
    input  dataOut, busy, regWrite, regAddr, regData, statusRead,
           vramReq, vramWe, vramAddr, vramWData
  );
endinterface

// File: rtl/vdp_write_fifo.sv
// CPU->VRAM write FIFO; the head entry is held in a register so it can drive the
// VRAM request directly while the entry waits for its ack.
module vdp_write_fifo #(
  parameter int W     = 22,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic [W-1:0]  head_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = head_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      // next head comes from storage unless the FIFO is (about to be) empty
      if (do_pop && count_q > (PW+1)'(1))
        head_q <= mem_q[rd_ptr_q + PW'(1)];
      else if (do_push && (empty_o || do_pop))
        head_q <= wdata_i;
    end
  end
endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-facing responder of the VDP: control/data port decode, write FIFO and read-ahead.
// seq: IDLE = no VRAM request | WREQ = writing FIFO head | RREQ = prefetch read in flight
module vdp_cpu_port #(
  parameter int VRAM_AW    = vdp_pkg::VRAM_AW,
  parameter int FIFO_DEPTH = vdp_pkg::FIFO_DEPTH,
  parameter int REG_AW     = vdp_pkg::REG_AW
) (
  input logic            clk,
  input logic            reset,
  vdp_cpu_port_if.slave  port_if
);
  import vdp_pkg::*;

  localparam int EW = VRAM_AW + 8;

  logic cs_wr, cs_rd, ctrl_wr, ctrl_rd, data_wr, data_rd;
  logic cmd_done, wr_setup, rd_setup, pf_set, rd_issue, rd_ack;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]      fifo_head;
  logic [VRAM_AW-1:0] setup_addr, addr_inc, pf_addr_d;

  latch_e             latch_q;
  seq_e               seq_q;
  logic [7:0]         lo_q, read_buf_q, data_out_q, reg_data_q, vram_wdata_q;
  logic [VRAM_AW-1:0] addr_q, pf_addr_q, vram_addr_q;
  logic [REG_AW-1:0]  reg_addr_q;
  logic               pf_pend_q, pf_redo_q, reg_write_q, status_read_q, vram_req_q, vram_we_q;

  assign cs_wr   = port_if.chipSelect & port_if.writeEnabled;
  assign cs_rd   = port_if.chipSelect & port_if.readStrobe & ~port_if.writeEnabled;
  assign ctrl_wr = cs_wr & port_if.mode;
  assign ctrl_rd = cs_rd & port_if.mode;
  assign data_wr = cs_wr & ~port_if.mode;
  assign data_rd = cs_rd & ~port_if.mode;

  assign cmd_done   = ctrl_wr & (latch_q == LATCH_SECOND);
  assign wr_setup   = cmd_done & (port_if.dataIn[7:6] == CMD_WR);
  assign rd_setup   = cmd_done & (port_if.dataIn[7:6] == CMD_RD);
  assign setup_addr = VRAM_AW'({port_if.dataIn[5:0], lo_q});
  assign addr_inc   = addr_q + VRAM_AW'(1);
  assign pf_set     = rd_setup | data_rd;
  assign pf_addr_d  = data_rd ? addr_inc : setup_addr;

  assign fifo_pop  = (seq_q == SEQ_WREQ) & port_if.vramAck;
  assign fifo_push = data_wr & (~fifo_full | fifo_pop);
  assign rd_ack    = (seq_q == SEQ_RREQ) & port_if.vramAck;
  assign rd_issue  = (seq_q == SEQ_IDLE) & fifo_empty & pf_pend_q;

  vdp_write_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i ({addr_q, port_if.dataIn}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q       <= LATCH_FIRST;
      lo_q          <= '0;
      addr_q        <= '0;
      data_out_q    <= '0;
      reg_write_q   <= 1'b0;
      reg_addr_q    <= '0;
      reg_data_q    <= '0;
      status_read_q <= 1'b0;
      read_buf_q    <= '0;
      pf_pend_q     <= 1'b0;
      pf_redo_q     <= 1'b0;
      pf_addr_q     <= '0;
    end else begin
      reg_write_q   <= 1'b0;
      status_read_q <= 1'b0;
      if (ctrl_wr) begin
        if (latch_q == LATCH_FIRST) begin
          lo_q    <= port_if.dataIn;
          latch_q <= LATCH_SECOND;
        end else begin
          latch_q <= LATCH_FIRST;
          if (cmd_is_reg(port_if.dataIn[7:6])) begin
            reg_write_q <= 1'b1;
            reg_addr_q  <= port_if.dataIn[REG_AW-1:0];
            reg_data_q  <= lo_q;
          end
          if (wr_setup || rd_setup) addr_q <= setup_addr;
        end
      end else if (ctrl_rd) begin
        latch_q       <= LATCH_FIRST;
        data_out_q    <= port_if.status;
        status_read_q <= 1'b1;
      end else if (data_wr) begin
        latch_q <= LATCH_FIRST;
        if (fifo_push) addr_q <= addr_inc;
      end else if (data_rd) begin
        latch_q    <= LATCH_FIRST;
        data_out_q <= read_buf_q;
        addr_q     <= addr_inc;
      end

      if (pf_set) pf_addr_q <= pf_addr_d;
      // a prefetch requested while one is being issued or in flight must re-run afterwards
      if (rd_ack) begin
        read_buf_q <= port_if.vramRData;
        pf_pend_q  <= pf_redo_q | pf_set;
        pf_redo_q  <= 1'b0;
      end else if (pf_set) begin
        if (seq_q == SEQ_RREQ || rd_issue) pf_redo_q <= 1'b1;
        else                               pf_pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q        <= SEQ_IDLE;
      vram_req_q   <= 1'b0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
    end else begin
      case (seq_q)
        SEQ_IDLE: begin
          if (!fifo_empty) begin
            vram_req_q   <= 1'b1;
            vram_we_q    <= 1'b1;
            vram_addr_q  <= fifo_head[EW-1:8];
            vram_wdata_q <= fifo_head[7:0];
            seq_q        <= SEQ_WREQ;
          end else if (pf_pend_q) begin
            vram_req_q  <= 1'b1;
            vram_we_q   <= 1'b0;
            vram_addr_q <= pf_addr_q;
            seq_q       <= SEQ_RREQ;
          end
        end
        SEQ_WREQ, SEQ_RREQ: begin
          if (port_if.vramAck) begin
            vram_req_q <= 1'b0;
            vram_we_q  <= 1'b0;
            seq_q      <= SEQ_IDLE;
          end
        end
        default: seq_q <= SEQ_IDLE;
      endcase
    end
  end

  assign port_if.dataOut    = data_out_q;
  assign port_if.busy       = ~fifo_empty | pf_pend_q | vram_req_q;
  assign port_if.regWrite   = reg_write_q;
  assign port_if.regAddr    = reg_addr_q;
  assign port_if.regData    = reg_data_q;
  assign port_if.statusRead = status_read_q;
  assign port_if.vramReq    = vram_req_q;
  assign port_if.vramWe     = vram_we_q;
  assign port_if.vramAddr   = vram_addr_q;
  assign port_if.vramWData  = vram_wdata_q;
endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: directed scenarios plus random CPU traffic against a VRAM model.
module tb_vdp_cpu_port;
  localparam int DEPTH = vdp_pkg::FIFO_DEPTH;
  localparam int ASIZE = 16384;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vdp_cpu_port_if bus_if ();
  vdp_cpu_port dut (.clk(clk), .reset(reset), .port_if(bus_if));

  int n_vec = 0, n_err = 0;
  int n_wr = 0, n_rd = 0, n_regw = 0, lat_cnt = 0;
  logic hold_ack;
  logic [7:0] tb_vram [ASIZE];

  // reference model state
  logic [7:0]  m_mem [ASIZE];
  logic [21:0] exp_wr [$];
  int m_addr, m_buf_addr, m_held, m_regs;
  logic [7:0] m_lo, m_buf;
  logic m_second, m_pf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // VRAM slot responder with random grant latency
  always @(negedge clk) begin
    logic [21:0] e;
    if (reset) begin
      bus_if.vramAck = 1'b0;
      lat_cnt = 0;
    end else if (bus_if.vramAck) begin
      bus_if.vramAck = 1'b0;
    end else if (bus_if.vramReq && !hold_ack) begin
      if (lat_cnt != 0) lat_cnt--;
      else begin
        bus_if.vramAck = 1'b1;
        lat_cnt = $urandom_range(0, 2);
        if (bus_if.vramWe) begin
          n_wr++;
          tb_vram[bus_if.vramAddr] = bus_if.vramWData;
          if (exp_wr.size() == 0)
            chk("wr_unexpected", {10'h0, bus_if.vramAddr, bus_if.vramWData}, 32'hFFFF_FFFF);
          else begin
            e = exp_wr.pop_front();
            chk("wr_addr", bus_if.vramAddr, e[21:8]);
            chk("wr_data", bus_if.vramWData, e[7:0]);
          end
        end else begin
          n_rd++;
          bus_if.vramRData = tb_vram[bus_if.vramAddr];
        end
      end
    end
  end

  always @(negedge clk) if (!reset && bus_if.regWrite) n_regw++;

  task automatic bus_cycle(input logic md, input logic wr, input logic rd, input logic [7:0] d);
    @(negedge clk);
    bus_if.chipSelect = 1'b1; bus_if.mode = md;
    bus_if.writeEnabled = wr; bus_if.readStrobe = rd; bus_if.dataIn = d;
    @(negedge clk);
    bus_if.chipSelect = 1'b0; bus_if.writeEnabled = 1'b0; bus_if.readStrobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_addr = 0; m_second = 0; m_buf = 8'h00; m_pf = 0; m_held = 0;
    m_regs = n_regw;
    exp_wr.delete();
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (bus_if.busy && k < 200) begin @(negedge clk); k++; end
    chk("idle", bus_if.busy, 0);
    if (m_pf) begin m_buf = m_mem[m_buf_addr]; m_pf = 0; end
  endtask

  task automatic ctrl_write(input logic [7:0] b);
    bus_cycle(1'b1, 1'b1, 1'b0, b);
    if (!m_second) begin
      m_lo = b; m_second = 1;
    end else begin
      m_second = 0;
      if (b >= 8'h80) begin
        chk("reg_we", bus_if.regWrite, 1);
        chk("reg_addr", bus_if.regAddr, b % 8);
        chk("reg_data", bus_if.regData, m_lo);
        m_regs++;
      end else begin
        m_addr = (b % 64) * 256 + m_lo;
        if (b < 8'h40) begin m_pf = 1; m_buf_addr = m_addr; end
      end
    end
  endtask

  task automatic data_write(input logic [7:0] d);
    bus_cycle(1'b0, 1'b1, 1'b0, d);
    m_second = 0;
    if (!hold_ack || m_held < DEPTH) begin
      exp_wr.push_back({14'(m_addr), d});
      m_mem[m_addr] = d;
      m_addr = (m_addr + 1) % ASIZE;
      m_held++;
    end
  endtask

  task automatic data_read();
    bus_cycle(1'b0, 1'b0, 1'b1, 8'h00);
    m_second = 0;
    chk("rd_data", bus_if.dataOut, m_buf);
    m_addr = (m_addr + 1) % ASIZE;
    m_buf_addr = m_addr; m_pf = 1;
  endtask

  task automatic ctrl_read(input logic [7:0] st);
    bus_if.status = st;
    bus_cycle(1'b1, 1'b0, 1'b1, 8'h00);
    m_second = 0;
    chk("status_data", bus_if.dataOut, st);
    chk("status_pulse", bus_if.statusRead, 1);
  endtask

  function automatic logic [5:0] rand_hi();
    return ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom_range(0, 1));
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    int base_wr, k;
    logic [7:0] v;
    reset = 1'b1; hold_ack = 1'b0;
    bus_if.chipSelect = 0; bus_if.mode = 0; bus_if.writeEnabled = 0;
    bus_if.readStrobe = 0; bus_if.dataIn = 0; bus_if.status = 0;
    for (int i = 0; i < ASIZE; i++) begin
      v = 8'($urandom); tb_vram[i] = v; m_mem[i] = v;
    end
    tb_vram[16'h3FFF] = 8'h11; m_mem[16'h3FFF] = 8'h11;
    tb_vram[0] = 8'h22;        m_mem[0] = 8'h22;
    repeat (3) @(negedge clk);
    do_reset();

    // reset state
    chk("rst_dataOut", bus_if.dataOut, 0);
    chk("rst_regWrite", bus_if.regWrite, 0);
    chk("rst_regAddr", bus_if.regAddr, 0);
    chk("rst_regData", bus_if.regData, 0);
    chk("rst_statusRead", bus_if.statusRead, 0);
    chk("rst_vramReq", bus_if.vramReq, 0);
    chk("rst_vramWe", bus_if.vramWe, 0);
    chk("rst_vramAddr", bus_if.vramAddr, 0);
    chk("rst_vramWData", bus_if.vramWData, 0);
    chk("rst_busy", bus_if.busy, 0);
    data_read();
    wait_idle();

    // 1: write setup 0x1234, two data writes
    ctrl_write(8'h34); ctrl_write(8'h52);
    data_write(8'hAA); data_write(8'hBB);
    chk("t1_busy", bus_if.busy, 1);
    wait_idle();
    chk("t1_writes_left", exp_wr.size(), 0);

    // 2: register write, no VRAM traffic
    base_wr = n_wr + n_rd;
    ctrl_write(8'h07); ctrl_write(8'h81);
    repeat (4) @(negedge clk);
    chk("t2_no_vram", n_wr + n_rd, base_wr);
    chk("t2_reg_pulses", n_regw, m_regs);

    // 3: read setup at 0x3FFF with wrap to 0x0000
    ctrl_write(8'hFF); ctrl_write(8'h3F);
    wait_idle();
    data_read(); wait_idle();
    data_read(); wait_idle();

    // 4: FIFO overflow while grants are held off
    ctrl_write(8'h00); ctrl_write(8'h41);
    wait_idle();
    base_wr = n_wr;
    hold_ack = 1'b1; m_held = 0;
    for (int i = 0; i < 5; i++) data_write(8'($urandom));
    chk("t4_busy", bus_if.busy, 1);
    hold_ack = 1'b0;
    wait_idle();
    chk("t4_writes_left", exp_wr.size(), 0);
    chk("t4_write_count", n_wr - base_wr, 4);
    data_write(8'hC5);
    wait_idle();
    chk("t4_next_addr", exp_wr.size(), 0);

    // 5: queued write precedes the read-ahead
    ctrl_write(8'h00); ctrl_write(8'h40);
    data_write(8'h5A);
    ctrl_write(8'h00); ctrl_write(8'h00);
    wait_idle();
    data_read();
    wait_idle();

    // 6: status read clears the byte latch
    ctrl_write(8'h12);
    ctrl_read(8'h80);
    @(negedge clk);
    chk("t6_pulse_end", bus_if.statusRead, 0);
    ctrl_write(8'h00); ctrl_write(8'h40);
    data_write(8'h77);
    wait_idle();
    chk("t6_writes_left", exp_wr.size(), 0);
    chk("t6_reg_pulses", n_regw, m_regs);

    // reset while a request is pending
    hold_ack = 1'b1; m_held = 0;
    data_write(8'h99);
    k = 0;
    while (!bus_if.vramReq && k < 10) begin @(negedge clk); k++; end
    chk("mid_req_seen", bus_if.vramReq, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", bus_if.vramReq, 0);
    do_reset();
    hold_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_busy", bus_if.busy, 0);

    // random traffic
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0: begin ctrl_write(8'($urandom)); ctrl_write({2'b01, rand_hi()}); wait_idle(); end
        1: begin ctrl_write(8'($urandom)); ctrl_write({2'b00, rand_hi()}); wait_idle(); end
        2: begin ctrl_write(8'($urandom)); ctrl_write({1'b1, 7'($urandom)}); end
        3: begin
          k = $urandom_range(1, DEPTH);
          for (int j = 0; j < k; j++) data_write(8'($urandom));
          wait_idle();
        end
        4: begin data_read(); wait_idle(); end
        default: begin
          if ($urandom_range(0, 1) == 1) ctrl_write(8'($urandom));
          ctrl_read(8'($urandom));
        end
      endcase
    end
    wait_idle();
    chk("rand_writes_left", exp_wr.size(), 0);
    repeat (2) @(negedge clk);
    chk("rand_reg_pulses", n_regw, m_regs);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
